// File: rtl/spi_engine_cmd_executor.sv
// SPI engine command executor: decodes 16-bit commands and drives sclk/sdo/cs.
// Received sdi words and sync IDs are returned on valid/ready streams.
module spi_engine_cmd_executor #(
  parameter int         DATA_WIDTH      = 8,
  parameter int         NUM_OF_CS       = 1,
  parameter logic [7:0] DEFAULT_CLK_DIV = 8'd0
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  cmd_ready,
  input  logic                  cmd_valid,
  input  logic [15:0]           cmd_data,
  output logic                  sdo_data_ready,
  input  logic                  sdo_data_valid,
  input  logic [DATA_WIDTH-1:0] sdo_data,
  input  logic                  sdi_data_ready,
  output logic                  sdi_data_valid,
  output logic [DATA_WIDTH-1:0] sdi_data,
  input  logic                  sync_ready,
  output logic                  sync_valid,
  output logic [7:0]            sync_data,
  output logic                  sclk,
  output logic                  sdo,
  input  logic                  sdi,
  output logic [NUM_OF_CS-1:0]  cs,
  output logic                  active
);

  localparam int EW = $clog2(2 * DATA_WIDTH);
  localparam logic [EW-1:0] LAST_EDGE = EW'(2 * DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE, XFER_LOAD, XFER_SHIFT, XFER_STORE, SYNC, SLEEP
  } state_t;

  state_t                state_q, state_d;
  logic                  init_q, init_d;
  logic [NUM_OF_CS-1:0]  cs_q, cs_d;
  logic [7:0]            clk_div_q, clk_div_d;
  logic                  cpol_q, cpol_d, cpha_q, cpha_d;
  logic                  rd_q, rd_d, wr_q, wr_d;
  logic [7:0]            count_q, count_d;
  logic [7:0]            half_q, half_d;
  logic [EW-1:0]         edge_q, edge_d;
  logic [18:0]           sleep_q, sleep_d;
  logic [7:0]            sync_id_q, sync_id_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, rx_q, rx_d;
  logic                  sclk_q, sclk_d, sdo_q, sdo_d;

  logic [DATA_WIDTH-1:0] word;
  logic [17:0]           sleep_prod;
  logic                  sample_edge;
  logic                  unused_cmd_bits;

  assign unused_cmd_bits = ^cmd_data[11:10];
  assign sleep_prod  = 18'({1'b0, cmd_data[7:0]} + 9'd1) * 18'({1'b0, clk_div_q} + 9'd1);
  // Leading edge leaves the idle level; cpha selects whether it samples or shifts.
  assign sample_edge = (sclk_q == cpol_q) ^ cpha_q;

  assign cmd_ready      = (state_q == IDLE) && init_q;
  assign sdo_data_ready = (state_q == XFER_LOAD) && wr_q;
  assign sdi_data_valid = (state_q == XFER_STORE);
  assign sdi_data       = rx_q;
  assign sync_valid     = (state_q == SYNC);
  assign sync_data      = sync_id_q;
  assign sclk           = sclk_q;
  assign sdo            = sdo_q;
  assign cs             = cs_q;
  assign active         = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    init_d    = 1'b1;
    cs_d      = cs_q;
    clk_div_d = clk_div_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    rd_d      = rd_q;
    wr_d      = wr_q;
    count_d   = count_q;
    half_d    = half_q;
    edge_d    = edge_q;
    sleep_d   = sleep_q;
    sync_id_d = sync_id_q;
    shift_d   = shift_q;
    rx_d      = rx_q;
    sdo_d     = sdo_q;
    sclk_d    = (state_q == XFER_SHIFT) ? sclk_q : cpol_q;
    word      = '0;

    case (state_q)
      IDLE: begin
        if (cmd_ready && cmd_valid) begin
          case (cmd_data[15:12])
            4'h0: begin
              rd_d    = cmd_data[9];
              wr_d    = cmd_data[8];
              count_d = cmd_data[7:0];
              state_d = XFER_LOAD;
            end
            4'h1: cs_d = cmd_data[NUM_OF_CS-1:0];
            4'h2: begin
              if (cmd_data[9:8] == 2'd0) begin
                clk_div_d = cmd_data[7:0];
              end else if (cmd_data[9:8] == 2'd1) begin
                cpha_d = cmd_data[0];
                cpol_d = cmd_data[1];
              end
            end
            4'h3: begin
              sync_id_d = cmd_data[7:0];
              state_d   = SYNC;
            end
            4'h4: begin
              sleep_d = {sleep_prod, 1'b0} - 19'd1;
              state_d = SLEEP;
            end
            default: ;
          endcase
        end
      end

      XFER_LOAD: begin
        if (!wr_q || sdo_data_valid) begin
          word = wr_q ? sdo_data : '0;
          // With cpha=0 the first bit must sit on sdo before the leading edge.
          if (cpha_q) begin
            shift_d = word;
          end else begin
            sdo_d   = word[DATA_WIDTH-1];
            shift_d = word << 1;
          end
          half_d  = clk_div_q;
          edge_d  = LAST_EDGE;
          state_d = XFER_SHIFT;
        end
      end

      XFER_SHIFT: begin
        if (half_q == 8'd0) begin
          half_d = clk_div_q;
          sclk_d = ~sclk_q;
          if (sample_edge) begin
            rx_d = DATA_WIDTH'({rx_q, sdi});
          end else begin
            sdo_d   = shift_q[DATA_WIDTH-1];
            shift_d = shift_q << 1;
          end
          if (edge_q == '0) begin
            if (rd_q) begin
              state_d = XFER_STORE;
            end else if (count_q == 8'd0) begin
              state_d = IDLE;
            end else begin
              count_d = count_q - 1'b1;
              state_d = XFER_LOAD;
            end
          end else begin
            edge_d = edge_q - 1'b1;
          end
        end else begin
          half_d = half_q - 1'b1;
        end
      end

      XFER_STORE: begin
        if (sdi_data_ready) begin
          if (count_q == 8'd0) begin
            state_d = IDLE;
          end else begin
            count_d = count_q - 1'b1;
            state_d = XFER_LOAD;
          end
        end
      end

      SYNC: if (sync_ready) state_d = IDLE;

      SLEEP: begin
        if (sleep_q == 19'd0) state_d = IDLE;
        else                  sleep_d = sleep_q - 1'b1;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= IDLE;
      init_q    <= 1'b0;
      cs_q      <= '1;
      clk_div_q <= DEFAULT_CLK_DIV;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      rd_q      <= 1'b0;
      wr_q      <= 1'b0;
      count_q   <= '0;
      half_q    <= '0;
      edge_q    <= '0;
      sleep_q   <= '0;
      sync_id_q <= '0;
      shift_q   <= '0;
      rx_q      <= '0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      cs_q      <= cs_d;
      clk_div_q <= clk_div_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      rd_q      <= rd_d;
      wr_q      <= wr_d;
      count_q   <= count_d;
      half_q    <= half_d;
      edge_q    <= edge_d;
      sleep_q   <= sleep_d;
      sync_id_q <= sync_id_d;
      shift_q   <= shift_d;
      rx_q      <= rx_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
    end
  end

endmodule

// File: tb/tb_spi_engine_cmd_executor.sv
// Directed bench for spi_engine_cmd_executor: a behavioural SPI slave drives sdi and
// records sdo on the sampling edge implied by the bench's own cpol/cpha settings.
module tb_spi_engine_cmd_executor;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        cmd_ready;
  logic        cmd_valid = 1'b0;
  logic [15:0] cmd_data = '0;
  logic        sdo_data_ready;
  logic        sdo_data_valid = 1'b0;
  logic [7:0]  sdo_data = '0;
  logic        sdi_data_ready = 1'b0;
  logic        sdi_data_valid;
  logic [7:0]  sdi_data;
  logic        sync_ready = 1'b0;
  logic        sync_valid;
  logic [7:0]  sync_data;
  logic        sclk;
  logic        sdo;
  logic        sdi = 1'b0;
  logic [0:0]  cs;
  logic        active;

  always #5 clk = ~clk;

  spi_engine_cmd_executor #(
    .DATA_WIDTH(8), .NUM_OF_CS(1), .DEFAULT_CLK_DIV(8'd0)
  ) dut (
    .clk(clk), .rstn(rstn),
    .cmd_ready(cmd_ready), .cmd_valid(cmd_valid), .cmd_data(cmd_data),
    .sdo_data_ready(sdo_data_ready), .sdo_data_valid(sdo_data_valid), .sdo_data(sdo_data),
    .sdi_data_ready(sdi_data_ready), .sdi_data_valid(sdi_data_valid), .sdi_data(sdi_data),
    .sync_ready(sync_ready), .sync_valid(sync_valid), .sync_data(sync_data),
    .sclk(sclk), .sdo(sdo), .sdi(sdi), .cs(cs), .active(active)
  );

  int   checks = 0;
  int   passed = 0;
  logic cpol_m = 1'b0;
  logic cpha_m = 1'b0;
  logic       tx_bits[$];
  logic [7:0] sdo_words[$];
  logic [7:0] rx_words[$];
  logic       sdo_seen[$];
  int   toggles, first_t, last_t;
  int   stall_len = 0;
  logic stall_sclk_bad, stall_data_bad;

  task automatic push_bits(input logic [7:0] w);
    for (int b = 7; b >= 0; b--) tx_bits.push_back(w[b]);
  endtask

  task automatic send_cmd(input logic [15:0] w);
    int n;
    n = 0;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_data  = w;
    while (cmd_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      $display("FAIL cmd_accept_timeout: cmd 0x%04h not accepted after %0d cycles", w, n);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  // Slave model: runs until the executor returns to IDLE or max_cyc expires.
  task automatic run_slave(input int max_cyc);
    logic prev, acc_pend, ref_set, ref_sclk;
    logic [7:0] ref_data;
    int cyc, stall_left;
    prev = sclk; acc_pend = 1'b0; ref_set = 1'b0; ref_sclk = 1'b0; ref_data = '0;
    stall_left = stall_len;
    toggles = 0; first_t = -1; last_t = -1;
    stall_sclk_bad = 1'b0; stall_data_bad = 1'b0;
    sdo_seen.delete(); rx_words.delete();
    if (!cpha_m) sdi = (tx_bits.size() > 0) ? tx_bits.pop_front() : 1'b0;
    cyc = 0;
    while (cyc < max_cyc) begin
      @(negedge clk);
      cyc++;
      if (acc_pend) begin
        if (sdo_words.size() > 0) sdo_data = sdo_words.pop_front();
        else sdo_data_valid = 1'b0;
        acc_pend = 1'b0;
      end
      if (sdo_data_valid && sdo_data_ready) acc_pend = 1'b1;
      if (sclk !== prev) begin
        toggles++;
        if (first_t < 0) first_t = cyc;
        last_t = cyc;
        if ((prev == cpol_m) != cpha_m) sdo_seen.push_back(sdo);
        else sdi = (tx_bits.size() > 0) ? tx_bits.pop_front() : 1'b0;
        prev = sclk;
      end
      sdi_data_ready = 1'b0;
      if (sdi_data_valid) begin
        if (stall_left > 0) begin
          if (!ref_set) begin
            ref_data = sdi_data; ref_sclk = sclk; ref_set = 1'b1;
          end else begin
            if (sdi_data !== ref_data) stall_data_bad = 1'b1;
            if (sclk !== ref_sclk || sclk !== cpol_m) stall_sclk_bad = 1'b1;
          end
          stall_left--;
        end else begin
          sdi_data_ready = 1'b1;
          rx_words.push_back(sdi_data);
        end
      end
      if (!active) break;
    end
    if (active) begin
      checks++;
      $display("FAIL slave_timeout: still active after %0d cycles, want idle", cyc);
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (cs !== 1'b1) $display("FAIL reset_cs: got %b want 1", cs); else passed++;
    checks++; if (sclk !== 1'b0) $display("FAIL reset_sclk: got %b want 0", sclk); else passed++;
    checks++; if (sdo !== 1'b0) $display("FAIL reset_sdo: got %b want 0", sdo); else passed++;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL reset_cmd_ready: got %b want 0", cmd_ready); else passed++;
    checks++; if ({sdi_data_valid, sync_valid, sdo_data_ready} !== 3'b000)
      $display("FAIL reset_valids: got %b want 000", {sdi_data_valid, sync_valid, sdo_data_ready}); else passed++;
    checks++; if (active !== 1'b0) $display("FAIL reset_active: got %b want 0", active); else passed++;
    rstn = 1'b1;
    checks++; if (cmd_ready !== 1'b0) $display("FAIL release_cmd_ready_early: got %b want 0", cmd_ready); else passed++;
    @(negedge clk);
    checks++; if (cmd_ready !== 1'b1) $display("FAIL release_cmd_ready: got %b want 1", cmd_ready); else passed++;
  endtask

  task automatic test_write();
    logic [7:0] got;
    send_cmd(16'h1000);
    checks++; if (cs !== 1'b0) $display("FAIL cs_assert: got %b want 0", cs); else passed++;
    sdo_data = 8'hA5; sdo_data_valid = 1'b1; sdo_words.delete();
    send_cmd(16'h0100);
    run_slave(200);
    got = '0;
    for (int b = 0; b < 8; b++) if (b < sdo_seen.size()) got[7-b] = sdo_seen[b];
    checks++; if (sdo_seen.size() != 8 || got !== 8'hA5)
      $display("FAIL write_sdo_bits: got 0x%02h (%0d bits) want 0xA5 (8 bits)", got, sdo_seen.size()); else passed++;
    checks++; if (toggles != 16 || last_t - first_t != 15)
      $display("FAIL write_sclk: got %0d edges span %0d want 16 edges span 15", toggles, last_t - first_t); else passed++;
    checks++; if (rx_words.size() != 0) $display("FAIL write_no_sdi: got %0d words want 0", rx_words.size()); else passed++;
    checks++; if (sdo_data_valid !== 1'b0) $display("FAIL write_sdo_consumed: valid %b want 0", sdo_data_valid); else passed++;
  endtask

  task automatic test_read_cpol_cpha();
    send_cmd(16'h2103);
    cpol_m = 1'b1; cpha_m = 1'b1;
    @(negedge clk); @(negedge clk);
    checks++; if (sclk !== 1'b1) $display("FAIL idle_sclk_cpol1: got %b want 1", sclk); else passed++;
    tx_bits.delete(); push_bits(8'h3C); push_bits(8'hC3);
    send_cmd(16'h0201);
    run_slave(200);
    checks++; if (rx_words.size() != 2) $display("FAIL read_count: got %0d want 2", rx_words.size()); else passed++;
    checks++; if (rx_words.size() == 2 && (rx_words[0] !== 8'h3C || rx_words[1] !== 8'hC3))
      $display("FAIL read_data: got 0x%02h 0x%02h want 0x3C 0xC3", rx_words[0], rx_words[1]); else passed++;
    checks++; if (toggles != 32 || sclk !== 1'b1)
      $display("FAIL read_sclk: got %0d edges end %b want 32 edges end 1", toggles, sclk); else passed++;
  endtask

  task automatic test_sdi_stall();
    tx_bits.delete(); push_bits(8'h5A); push_bits(8'h96);
    stall_len = 20;
    send_cmd(16'h0201);
    run_slave(400);
    stall_len = 0;
    checks++; if (rx_words.size() != 2) $display("FAIL stall_count: got %0d want 2", rx_words.size()); else passed++;
    checks++; if (rx_words.size() == 2 && (rx_words[0] !== 8'h5A || rx_words[1] !== 8'h96))
      $display("FAIL stall_data: got 0x%02h 0x%02h want 0x5A 0x96", rx_words[0], rx_words[1]); else passed++;
    checks++; if (stall_data_bad !== 1'b0) $display("FAIL stall_data_stable: changed=%b want 0", stall_data_bad); else passed++;
    checks++; if (stall_sclk_bad !== 1'b0) $display("FAIL stall_sclk_frozen: moved=%b want 0", stall_sclk_bad); else passed++;
    checks++; if (toggles != 32) $display("FAIL stall_edges: got %0d want 32", toggles); else passed++;
  endtask

  task automatic test_sync();
    int hi;
    logic [7:0] d;
    sync_ready = 1'b0;
    send_cmd(16'h3055);
    hi = 0; d = '0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (sync_valid) hi++;
      if (i == 1) d = sync_data;
      if (i == 6) sync_ready = 1'b1;
    end
    sync_ready = 1'b0;
    checks++; if (hi != 6) $display("FAIL sync_valid_len: got %0d want 6", hi); else passed++;
    checks++; if (d !== 8'h55) $display("FAIL sync_data: got 0x%02h want 0x55", d); else passed++;
    checks++; if (cmd_ready !== 1'b1) $display("FAIL sync_then_idle: cmd_ready %b want 1", cmd_ready); else passed++;
  endtask

  task automatic test_sleep_and_abort();
    int n, seen;
    logic bad;
    send_cmd(16'h2003);
    send_cmd(16'h4001);
    n = 0; bad = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (active) begin
        n++;
        if (sclk !== cpol_m) bad = 1'b1;
      end
    end
    checks++; if (n != 16) $display("FAIL sleep_len: got %0d want 16", n); else passed++;
    checks++; if (bad !== 1'b0) $display("FAIL sleep_sclk_idle: moved=%b want 0", bad); else passed++;
    send_cmd(16'h1000);
    tx_bits.delete(); sdi = 1'b1;
    send_cmd(16'h0200);
    repeat (12) @(negedge clk);
    checks++; if (active !== 1'b1 || cs !== 1'b0)
      $display("FAIL abort_midxfer: active %b cs %b want 1 0", active, cs); else passed++;
    rstn = 1'b0;
    @(negedge clk);
    checks++; if (cs !== 1'b1 || sclk !== 1'b0 || sdo !== 1'b0)
      $display("FAIL abort_pins: cs %b sclk %b sdo %b want 1 0 0", cs, sclk, sdo); else passed++;
    checks++; if ({active, cmd_ready, sdi_data_valid, sync_valid, sdo_data_ready} !== 5'b0)
      $display("FAIL abort_ctrl: got %b want 00000", {active, cmd_ready, sdi_data_valid, sync_valid, sdo_data_ready}); else passed++;
    @(negedge clk);
    rstn = 1'b1;
    cpol_m = 1'b0; cpha_m = 1'b0; sdi = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sdi_data_valid) seen++;
    end
    checks++; if (seen != 0) $display("FAIL abort_no_partial: got %0d valid cycles want 0", seen); else passed++;
    checks++; if (cmd_ready !== 1'b1 || sclk !== 1'b0)
      $display("FAIL abort_recover: cmd_ready %b sclk %b want 1 0", cmd_ready, sclk); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [15:0] got;
    sdo_data = 8'h81; sdo_data_valid = 1'b1;
    sdo_words.delete(); sdo_words.push_back(8'h7E);
    tx_bits.delete();
    send_cmd(16'h0101);
    run_slave(300);
    got = '0;
    for (int b = 0; b < 16; b++) if (b < sdo_seen.size()) got[15-b] = sdo_seen[b];
    checks++; if (sdo_seen.size() != 16 || got !== 16'h817E)
      $display("FAIL b2b_sdo: got 0x%04h (%0d bits) want 0x817E (16 bits)", got, sdo_seen.size()); else passed++;
    checks++; if (toggles != 32 || last_t - first_t != 32)
      $display("FAIL b2b_timing: got %0d edges span %0d want 32 edges span 32", toggles, last_t - first_t); else passed++;
  endtask

  task automatic test_max_count();
    int rx_err, tx_err;
    logic [7:0] wv;
    sdo_data = 8'h00; sdo_data_valid = 1'b1;
    sdo_words.delete(); tx_bits.delete();
    for (int i = 1; i < 256; i++) sdo_words.push_back(8'(i));
    for (int i = 0; i < 256; i++) push_bits(8'(i));
    send_cmd(16'h03FF);
    run_slave(8000);
    rx_err = 0; tx_err = 0;
    for (int i = 0; i < 256; i++) begin
      wv = 8'(i);
      if (i < rx_words.size() && rx_words[i] !== wv) rx_err++;
      for (int b = 0; b < 8; b++)
        if (8 * i + b < sdo_seen.size() && sdo_seen[8 * i + b] !== wv[7-b]) tx_err++;
    end
    checks++; if (rx_words.size() != 256) $display("FAIL max_count_words: got %0d want 256", rx_words.size()); else passed++;
    checks++; if (rx_err != 0) $display("FAIL max_count_rx: got %0d bad words want 0", rx_err); else passed++;
    checks++; if (sdo_seen.size() != 2048 || tx_err != 0)
      $display("FAIL max_count_tx: got %0d bits %0d bad want 2048 bits 0 bad", sdo_seen.size(), tx_err); else passed++;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_cpol_cpha();
    test_sdi_stall();
    test_sync();
    test_sleep_and_abort();
    test_back_to_back();
    test_max_count();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule
